// File: rtl/bf_io_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : bf_io_bridge_if
// Brief  : Core-side and host-side byte I/O bundle of the BF I/O bridge.
// Rev    : 1.0
// ============================================================================
interface bf_io_bridge_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          core_out;
   logic                core_out_enable;
   logic [7:0]          core_in;
   logic                core_in_take;
   logic                core_in_clock;
   logic [7:0]          host_out_data;
   logic                host_out_valid;
   logic                host_out_ready;
   logic [7:0]          host_in_data;
   logic                host_in_valid;
   logic                host_in_ready;
   logic [DEPTH_LOG2:0] out_count;
   logic [DEPTH_LOG2:0] in_count;
   logic                out_overflow;
   logic                in_underflow;
   logic                flags_clear;

   modport slave (
      input  core_out, core_out_enable, core_in_take, host_out_ready,
             host_in_data, host_in_valid, flags_clear,
      output core_in, core_in_clock, host_out_data, host_out_valid,
             host_in_ready, out_count, in_count, out_overflow, in_underflow
   );

   modport master (
      output core_out, core_out_enable, core_in_take, host_out_ready,
             host_in_data, host_in_valid, flags_clear,
      input  core_in, core_in_clock, host_out_data, host_out_valid,
             host_in_ready, out_count, in_count, out_overflow, in_underflow
   );
endinterface
`default_nettype wire

// File: rtl/bf_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : bf_io_bridge
// Brief  : First-word fall-through byte FIFOs between the BF core and the host.
// Rev    : 1.0
// ============================================================================
module bf_io_bridge #(
   parameter int         DEPTH_LOG2  = 4,
   parameter logic [7:0] EMPTY_VALUE = 8'h00
) (
   input  logic          clock,
   input  logic          reset_n,
   bf_io_bridge_if.slave bus
);
   localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_FULL    = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0] c_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

   // ---------------- output FIFO (core -> host) ----------------
   logic [7:0]            r_out_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_out_wptr;
   logic [DEPTH_LOG2-1:0] r_out_rptr;
   logic [DEPTH_LOG2:0]   r_out_count;
   logic                  r_out_overflow;
   logic                  w_out_full;
   logic                  w_out_pop;
   logic                  w_out_push;

   assign w_out_full = (r_out_count == c_FULL);
   assign w_out_pop  = (r_out_count != '0) && bus.host_out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_out_push = bus.core_out_enable && (!w_out_full || w_out_pop);

   always_ff @(posedge clock) begin
      if (w_out_push) r_out_mem[r_out_wptr] <= bus.core_out;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_wptr     <= '0;
         r_out_rptr     <= '0;
         r_out_count    <= '0;
         r_out_overflow <= 1'b0;
      end else begin
         if (w_out_push) r_out_wptr <= r_out_wptr + c_PTR_ONE;
         if (w_out_pop)  r_out_rptr <= r_out_rptr + c_PTR_ONE;
         if (w_out_push && !w_out_pop)      r_out_count <= r_out_count + c_CNT_ONE;
         else if (!w_out_push && w_out_pop) r_out_count <= r_out_count - c_CNT_ONE;
         if (bus.flags_clear)                          r_out_overflow <= 1'b0;
         else if (bus.core_out_enable && !w_out_push)  r_out_overflow <= 1'b1;
      end
   end

   // ---------------- input FIFO (host -> core) ----------------
   logic [7:0]            r_in_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_in_wptr;
   logic [DEPTH_LOG2-1:0] r_in_rptr;
   logic [DEPTH_LOG2:0]   r_in_count;
   logic                  r_in_underflow;
   logic                  r_in_clock;
   logic                  w_in_ready;
   logic                  w_in_empty;
   logic                  w_in_push;
   logic                  w_in_pop;

   assign w_in_ready = (r_in_count != c_FULL);
   assign w_in_empty = (r_in_count == '0);
   assign w_in_push  = bus.host_in_valid && w_in_ready;
   assign w_in_pop   = bus.core_in_take && !w_in_empty;

   always_ff @(posedge clock) begin
      if (w_in_push) r_in_mem[r_in_wptr] <= bus.host_in_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_in_wptr      <= '0;
         r_in_rptr      <= '0;
         r_in_count     <= '0;
         r_in_underflow <= 1'b0;
         r_in_clock     <= 1'b0;
      end else begin
         if (w_in_push) r_in_wptr <= r_in_wptr + c_PTR_ONE;
         if (w_in_pop)  r_in_rptr <= r_in_rptr + c_PTR_ONE;
         if (w_in_push && !w_in_pop)      r_in_count <= r_in_count + c_CNT_ONE;
         else if (!w_in_push && w_in_pop) r_in_count <= r_in_count - c_CNT_ONE;
         if (bus.flags_clear)                     r_in_underflow <= 1'b0;
         else if (bus.core_in_take && w_in_empty) r_in_underflow <= 1'b1;
         // Nothing can pop an empty FIFO, so a push while empty is the 0 -> 1 edge.
         r_in_clock <= w_in_empty && w_in_push;
      end
   end

   assign bus.host_out_data  = r_out_mem[r_out_rptr];
   assign bus.host_out_valid = (r_out_count != '0);
   assign bus.out_count      = r_out_count;
   assign bus.out_overflow   = r_out_overflow;
   assign bus.core_in        = w_in_empty ? EMPTY_VALUE : r_in_mem[r_in_rptr];
   assign bus.core_in_clock  = r_in_clock;
   assign bus.host_in_ready  = w_in_ready;
   assign bus.in_count       = r_in_count;
   assign bus.in_underflow   = r_in_underflow;
endmodule
`default_nettype wire

// File: tb/tb_bf_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_bf_io_bridge
// Brief  : Scoreboard bench for bf_io_bridge (DEPTH_LOG2 = 4).
// Rev    : 1.0
// ============================================================================
module tb_bf_io_bridge;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   bf_io_bridge_if #(.DEPTH_LOG2(4)) bus ();

   bf_io_bridge #(.DEPTH_LOG2(4), .EMPTY_VALUE(8'h00)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0] out_q[$];
   logic [7:0] in_q[$];
   int   m_out_cnt = 0;
   int   m_in_cnt  = 0;
   bit   m_ovf     = 1'b0;
   bit   m_unf     = 1'b0;
   bit   m_clk_exp = 1'b0;
   int   o_rcv     = 0;
   int   i_rcv     = 0;

   task automatic idle_inputs();
      bus.core_out        = 8'h00;
      bus.core_out_enable = 1'b0;
      bus.core_in_take    = 1'b0;
      bus.host_out_ready  = 1'b0;
      bus.host_in_data    = 8'h00;
      bus.host_in_valid   = 1'b0;
      bus.flags_clear     = 1'b0;
   endtask

   task automatic model_clear();
      out_q.delete();
      in_q.delete();
      m_out_cnt = 0; m_in_cnt = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_clk_exp = 1'b0;
   endtask

   // One clock: scoreboard update from the inputs as driven, edge, then monitor.
   task automatic cycle();
      bit opop, opush, ipop, ipush;
      logic [7:0] exp_in;
      opop = (m_out_cnt != 0) && bus.host_out_ready;
      if (opop) begin
         checks++;
         if (bus.host_out_data !== out_q[0]) begin
            failures++;
            $display("FAIL host_out_data: got %0h expected %0h", bus.host_out_data, out_q[0]);
         end
         void'(out_q.pop_front());
         o_rcv++;
      end
      opush = bus.core_out_enable && (m_out_cnt < 16 || opop);
      if (bus.core_out_enable && !opush) m_ovf = 1'b1;
      if (opush) out_q.push_back(bus.core_out);
      m_out_cnt += int'(opush) - int'(opop);

      ipop = bus.core_in_take && (m_in_cnt != 0);
      if (ipop) begin
         checks++;
         if (bus.core_in !== in_q[0]) begin
            failures++;
            $display("FAIL core_in_pop: got %0h expected %0h", bus.core_in, in_q[0]);
         end
         void'(in_q.pop_front());
         i_rcv++;
      end
      if (bus.core_in_take && m_in_cnt == 0) m_unf = 1'b1;
      ipush = bus.host_in_valid && (m_in_cnt < 16);
      m_clk_exp = (m_in_cnt == 0) && ipush;
      if (ipush) in_q.push_back(bus.host_in_data);
      m_in_cnt += int'(ipush) - int'(ipop);
      if (bus.flags_clear) begin m_ovf = 1'b0; m_unf = 1'b0; end

      @(posedge clock); #1;

      exp_in = (m_in_cnt != 0) ? in_q[0] : 8'h00;
      checks++;
      if (bus.out_count !== 5'(m_out_cnt) || bus.host_out_valid !== (m_out_cnt != 0)) begin
         failures++;
         $display("FAIL out_state: got count=%0d valid=%0b expected count=%0d valid=%0b",
                  bus.out_count, bus.host_out_valid, m_out_cnt, m_out_cnt != 0);
      end
      checks++;
      if (bus.in_count !== 5'(m_in_cnt) || bus.host_in_ready !== (m_in_cnt != 16)
          || bus.core_in !== exp_in) begin
         failures++;
         $display("FAIL in_state: got count=%0d ready=%0b core_in=%0h expected count=%0d ready=%0b core_in=%0h",
                  bus.in_count, bus.host_in_ready, bus.core_in, m_in_cnt, m_in_cnt != 16, exp_in);
      end
      checks++;
      if (bus.core_in_clock !== m_clk_exp || bus.out_overflow !== m_ovf
          || bus.in_underflow !== m_unf) begin
         failures++;
         $display("FAIL pulse_flags: got clk=%0b ovf=%0b unf=%0b expected clk=%0b ovf=%0b unf=%0b",
                  bus.core_in_clock, bus.out_overflow, bus.in_underflow, m_clk_exp, m_ovf, m_unf);
      end
   endtask

   task automatic check_reset_state(string name);
      checks++;
      if (bus.out_count !== 5'd0 || bus.in_count !== 5'd0 || bus.host_out_valid !== 1'b0
          || bus.host_in_ready !== 1'b1 || bus.core_in !== 8'h00 || bus.out_overflow !== 1'b0
          || bus.in_underflow !== 1'b0 || bus.core_in_clock !== 1'b0) begin
         failures++;
         $display("FAIL %s: got oc=%0d ic=%0d v=%0b r=%0b ci=%0h ovf=%0b unf=%0b clk=%0b expected 0 0 0 1 00 0 0 0",
                  name, bus.out_count, bus.in_count, bus.host_out_valid, bus.host_in_ready,
                  bus.core_in, bus.out_overflow, bus.in_underflow, bus.core_in_clock);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_state("reset_initial");
      reset_n = 1'b1;
      model_clear();
      // build up traffic in both FIFOs plus an overflow-free flag set, then reset mid-stream
      bus.core_out = 8'h11; bus.core_out_enable = 1'b1;
      bus.host_in_data = 8'h22; bus.host_in_valid = 1'b1;
      cycle();
      bus.core_in_take = 1'b0;
      cycle();
      idle_inputs();
      bus.core_in_take = 1'b1;
      bus.host_in_valid = 1'b0;
      cycle();
      cycle();
      cycle();
      idle_inputs();
      #2 reset_n = 1'b0;
      #1;
      check_reset_state("reset_midtraffic");
      model_clear();
      @(posedge clock); #1;
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_output_path();
      idle_inputs();
      bus.core_out = 8'h48; bus.core_out_enable = 1'b1;
      cycle();
      bus.core_out = 8'h69;
      cycle();
      bus.core_out_enable = 1'b0;
      checks++;
      if (bus.out_count !== 5'd2 || bus.host_out_data !== 8'h48) begin
         failures++;
         $display("FAIL out_path_hold: got count=%0d head=%0h expected count=2 head=48",
                  bus.out_count, bus.host_out_data);
      end
      bus.host_out_ready = 1'b1;
      cycle();
      cycle();
      bus.host_out_ready = 1'b0;
      checks++;
      if (bus.host_out_valid !== 1'b0 || o_rcv < 2) begin
         failures++;
         $display("FAIL out_path_drain: got valid=%0b expected valid=0", bus.host_out_valid);
      end
   endtask

   task automatic test_output_overflow();
      idle_inputs();
      for (int i = 0; i < 17; i++) begin
         bus.core_out = 8'(8'hA0 + i); bus.core_out_enable = 1'b1;
         cycle();
      end
      bus.core_out_enable = 1'b0;
      checks++;
      if (bus.out_count !== 5'd16 || bus.out_overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow_drop: got count=%0d ovf=%0b expected count=16 ovf=1",
                  bus.out_count, bus.out_overflow);
      end
      bus.host_out_ready = 1'b1;
      repeat (16) cycle();
      bus.host_out_ready = 1'b0;
      bus.flags_clear = 1'b1;
      cycle();
      bus.flags_clear = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.core_out = 8'(8'hC0 + i); bus.core_out_enable = 1'b1;
         bus.host_out_ready = (i == 16);
         cycle();
      end
      idle_inputs();
      checks++;
      if (bus.out_count !== 5'd16 || bus.out_overflow !== 1'b0 || bus.host_out_data !== 8'hC1) begin
         failures++;
         $display("FAIL overflow_pop: got count=%0d ovf=%0b head=%0h expected count=16 ovf=0 head=c1",
                  bus.out_count, bus.out_overflow, bus.host_out_data);
      end
      bus.host_out_ready = 1'b1;
      repeat (16) cycle();
      bus.host_out_ready = 1'b0;
   endtask

   task automatic test_input_path();
      idle_inputs();
      bus.host_in_data = 8'h41; bus.host_in_valid = 1'b1;
      cycle();
      bus.host_in_valid = 1'b0;
      checks++;
      if (bus.core_in !== 8'h41 || bus.core_in_clock !== 1'b1) begin
         failures++;
         $display("FAIL in_path_arrive: got core_in=%0h clk=%0b expected 41 1", bus.core_in, bus.core_in_clock);
      end
      cycle();
      checks++;
      if (bus.core_in_clock !== 1'b0) begin
         failures++;
         $display("FAIL in_path_pulse: got clk=%0b expected 0", bus.core_in_clock);
      end
      bus.core_in_take = 1'b1;
      cycle();
      bus.core_in_take = 1'b0;
      checks++;
      if (bus.in_count !== 5'd0 || bus.core_in !== 8'h00) begin
         failures++;
         $display("FAIL in_path_take: got count=%0d core_in=%0h expected 0 00", bus.in_count, bus.core_in);
      end
   endtask

   task automatic test_underflow();
      idle_inputs();
      bus.core_in_take = 1'b1;
      bus.host_in_data = 8'h7A; bus.host_in_valid = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.in_underflow !== 1'b1 || bus.in_count !== 5'd1 || bus.core_in !== 8'h7A) begin
         failures++;
         $display("FAIL underflow_set: got unf=%0b count=%0d core_in=%0h expected 1 1 7a",
                  bus.in_underflow, bus.in_count, bus.core_in);
      end
      bus.flags_clear = 1'b1;
      cycle();
      bus.flags_clear = 1'b0;
      checks++;
      if (bus.in_underflow !== 1'b0) begin
         failures++;
         $display("FAIL underflow_clear: got unf=%0b expected 0", bus.in_underflow);
      end
      bus.core_in_take = 1'b1;
      cycle();
      bus.core_in_take = 1'b0;
   endtask

   task automatic test_wrap();
      int o_sent = 0;
      int i_sent = 0;
      int o_base = o_rcv;
      int i_base = i_rcv;
      int max_cnt = 0;
      idle_inputs();
      for (int cyc = 0; cyc < 2000 && (o_rcv - o_base < 40 || i_rcv - i_base < 40); cyc++) begin
         bus.core_out_enable = (o_sent < 40) && (m_out_cnt < 16) && ($urandom_range(0, 3) != 0);
         bus.core_out        = 8'(8'h80 + o_sent);
         bus.host_out_ready  = ($urandom_range(0, 1) != 0);
         bus.host_in_valid   = (i_sent < 40) && ($urandom_range(0, 2) != 0);
         bus.host_in_data    = 8'(8'h10 + i_sent);
         bus.core_in_take    = (m_in_cnt != 0) && ($urandom_range(0, 2) == 0);
         if (bus.core_out_enable) o_sent++;
         if (bus.host_in_valid && m_in_cnt < 16) i_sent++;
         cycle();
         if (int'(bus.out_count) > max_cnt) max_cnt = int'(bus.out_count);
         if (int'(bus.in_count) > max_cnt)  max_cnt = int'(bus.in_count);
      end
      idle_inputs();
      checks++;
      if (o_rcv - o_base != 40 || i_rcv - i_base != 40) begin
         failures++;
         $display("FAIL wrap_complete: got out=%0d in=%0d expected 40 40", o_rcv - o_base, i_rcv - i_base);
      end
      checks++;
      if (max_cnt > 16) begin
         failures++;
         $display("FAIL wrap_bound: got max count=%0d expected <=16", max_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_output_path();
      test_output_overflow();
      test_input_path();
      test_underflow();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
